// File: rtl/dmix_pkg.sv
// Shared mix-path constants, types and small helpers for the I2S output stage.
// Pure declarations: no latency, no flow control.
package dmix_pkg;

    localparam int I2S_FRAME_BITS = 64;
    localparam int I2S_SLOT_BITS  = 32;
    localparam int SAMPLE_W       = 24;
    localparam int POP_BIT_L      = 4;
    localparam int POP_BIT_R      = 36;
    localparam int CH_L           = 0;
    localparam int CH_R           = 1;
    localparam int UCNT_W         = 16;

    typedef logic [SAMPLE_W-1:0]      sample_t;
    typedef logic [I2S_SLOT_BITS-1:0] slot_t;

    // I2S slot: one leading zero bit (the one-BCK delay after LRCK), sample MSB first, zero pad.
    function automatic slot_t slot_word(input sample_t s);
        return {1'b0, s, {(I2S_SLOT_BITS - SAMPLE_W - 1){1'b0}}};
    endfunction

    function automatic logic [UCNT_W-1:0] sat_inc(input logic [UCNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dac_i2s_chbuf.sv
// Per-channel sample buffer: holds the latest acked sample until the slot load consumes it.
// Latency: ack visible in pending next cycle, same-cycle ack bypasses to the load; no backpressure.
module dac_i2s_chbuf
    import dmix_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                ack,
    input  logic [SAMPLE_W-1:0] data,
    input  logic                load,
    output logic [SAMPLE_W-1:0] sample,
    output logic                underrun
);

    logic [SAMPLE_W-1:0] pending;
    logic                pend_v;
    logic                primed;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= '0;
            pend_v  <= 1'b0;
            primed  <= 1'b0;
        end else begin
            if (ack) begin
                pending <= data;
                primed  <= 1'b1;
            end
            // A load consumes whatever is there, including a same-cycle ack.
            if (load) begin
                pend_v <= 1'b0;
            end else if (ack) begin
                pend_v <= 1'b1;
            end
        end
    end

    always_comb begin
        sample   = '0;
        underrun = 1'b0;
        if (ack) begin
            sample = data;
        end else if (pend_v) begin
            sample = pending;
        end else begin
            underrun = load & primed;
        end
    end

endmodule

// File: rtl/dac_i2s_tx.sv
// I2S transmitter: pops stereo samples from the mixer once per frame and serialises 64 BCK/frame.
// Latency: slot loaded at its first cycle, MSB on pin one BCK later; no backpressure, late data underruns.
module dac_i2s_tx
    import dmix_pkg::*;
#(
    parameter int CLK_PER_BCK_LOG2 = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic [1:0]          pop_o,
    input  logic [SAMPLE_W-1:0] data_i,
    input  logic [1:0]          ack_i,
    output logic                bck_o,
    output logic                lrck_o,
    output logic                data_o,
    output logic                underrun_o,
    output logic [UCNT_W-1:0]   underrun_cnt_o
);

    localparam int LG = CLK_PER_BCK_LOG2;
    localparam int CW = $clog2(I2S_FRAME_BITS) + LG;

    localparam logic [CW-1:0] LOAD_L_CNT = '0;
    localparam logic [CW-1:0] LOAD_R_CNT = CW'(I2S_SLOT_BITS << LG);
    localparam logic [CW-1:0] POP_L_CNT  = CW'(POP_BIT_L << LG);
    localparam logic [CW-1:0] POP_R_CNT  = CW'(POP_BIT_R << LG);

    logic [CW-1:0]       cnt;
    logic                bit_edge;
    logic                load_l;
    logic                load_r;
    logic [SAMPLE_W-1:0] smp_l;
    logic [SAMPLE_W-1:0] smp_r;
    logic                urun_l;
    logic                urun_r;
    slot_t               shift;
    slot_t               shift_n;
    logic [UCNT_W-1:0]   urun_cnt;

    assign bit_edge = (cnt[LG-1:0] == '0);
    assign load_l   = (cnt == LOAD_L_CNT);
    assign load_r   = (cnt == LOAD_R_CNT);

    // Pops are a pure decode of the free-running counter: one cycle per channel per frame.
    assign pop_o[CH_L] = (cnt == POP_L_CNT);
    assign pop_o[CH_R] = (cnt == POP_R_CNT);

    assign underrun_cnt_o = urun_cnt;

    dac_i2s_chbuf u_buf_l (
        .clk      (clk),
        .rst      (rst),
        .ack      (ack_i[CH_L]),
        .data     (data_i),
        .load     (load_l),
        .sample   (smp_l),
        .underrun (urun_l)
    );

    dac_i2s_chbuf u_buf_r (
        .clk      (clk),
        .rst      (rst),
        .ack      (ack_i[CH_R]),
        .data     (data_i),
        .load     (load_r),
        .sample   (smp_r),
        .underrun (urun_r)
    );

    always_comb begin
        shift_n = shift;
        if (load_l) begin
            shift_n = slot_word(smp_l);
        end else if (load_r) begin
            shift_n = slot_word(smp_r);
        end else if (bit_edge) begin
            shift_n = {shift[I2S_SLOT_BITS-2:0], 1'b0};
        end
    end

    // Pins are all registered off the same edge; data updates on the edge that drops bck_o.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt        <= '0;
            shift      <= '0;
            bck_o      <= 1'b0;
            lrck_o     <= 1'b0;
            data_o     <= 1'b0;
            underrun_o <= 1'b0;
            urun_cnt   <= '0;
        end else begin
            cnt        <= cnt + 1'b1;
            shift      <= shift_n;
            bck_o      <= cnt[LG-1];
            lrck_o     <= cnt[CW-1];
            if (bit_edge) begin
                data_o <= shift_n[I2S_SLOT_BITS-1];
            end
            underrun_o <= urun_l | urun_r;
            if (urun_l | urun_r) begin
                urun_cnt <= sat_inc(urun_cnt);
            end
        end
    end

endmodule

// File: tb/tb_dac_i2s_tx.sv
// Self-checking bench for dac_i2s_tx: per-cycle pin comparison against a frame-level reference model.
// Expected pin values come from the I2S slot rules and the "latest ack since the previous load" rule.
module tb_dac_i2s_tx;

    localparam int MAXC = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  pop_o;
    logic [23:0] data_i;
    logic [1:0]  ack_i;
    logic        bck_o;
    logic        lrck_o;
    logic        data_o;
    logic        underrun_o;
    logic [15:0] underrun_cnt_o;

    always #5 clk = ~clk;

    dac_i2s_tx #(.CLK_PER_BCK_LOG2(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .pop_o          (pop_o),
        .data_i         (data_i),
        .ack_i          (ack_i),
        .bck_o          (bck_o),
        .lrck_o         (lrck_o),
        .data_o         (data_o),
        .underrun_o     (underrun_o),
        .underrun_cnt_o (underrun_cnt_o)
    );

    int          errors = 0;
    int          checks = 0;
    int          n;
    int          ucnt_m;
    int          pulses;
    int          ones;
    logic [24:0] plan [2][MAXC];
    logic [31:0] rx_cur;
    logic [31:0] rx_slot [64];

    task automatic clear_state();
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < MAXC; k++)
                plan[c][k] = '0;
        for (int k = 0; k < 64; k++)
            rx_slot[k] = '0;
        rx_cur = '0;
        n      = 0;
        ucnt_m = 0;
        pulses = 0;
        ones   = 0;
    endtask

    task automatic plan_ack(input int ch, input int cyc, input logic [23:0] d);
        if (cyc >= 0 && cyc < MAXC) plan[ch][cyc] = {1'b1, d};
    endtask

    // Sample sent at the load in cycle t: newest ack in (t-256, t]; none but ever acked -> underrun.
    task automatic load_model(input int ch, input int t, output logic [23:0] s, output bit ur);
        bit found;
        bit primed;
        found  = 0;
        primed = 0;
        s      = '0;
        for (int k = t; k >= 0; k--) begin
            if (plan[ch][k][24]) begin
                primed = 1;
                if (k > t - 256) begin
                    s     = plan[ch][k][23:0];
                    found = 1;
                end
                break;
            end
        end
        ur = primed && !found;
    endtask

    task automatic check_cycle();
        logic [21:0] exp_v;
        logic [21:0] obs_v;
        logic [1:0]  e_pop;
        logic        e_bck, e_lr, e_dat, e_ur;
        logic [23:0] s;
        bit          ur;
        int          m, bb, ch, j;
        e_pop = {(n % 256) == 144, (n % 256) == 16};
        e_bck = 0; e_lr = 0; e_dat = 0; e_ur = 0;
        if (n > 0) begin
            m     = n - 1;
            e_bck = ((m >> 1) & 1) != 0;
            e_lr  = ((m >> 7) & 1) != 0;
            bb    = (m >> 2) & 63;
            ch    = bb >> 5;
            j     = bb & 31;
            load_model(ch, m - (m & 127), s, ur);
            e_dat = (j >= 1 && j <= 24) ? s[24-j] : 1'b0;
            if ((m & 127) == 0) begin
                load_model((m >> 7) & 1, m, s, ur);
                e_ur = ur;
                if (ur && ucnt_m < 65535) ucnt_m++;
            end
            if ((m & 3) == 0) begin
                rx_cur = {rx_cur[30:0], data_o};
                if (j == 31) rx_slot[(m >> 7) & 63] = rx_cur;
            end
        end
        exp_v = {e_pop, e_bck, e_lr, e_dat, e_ur, 16'(ucnt_m)};
        obs_v = {pop_o, bck_o, lrck_o, data_o, underrun_o, underrun_cnt_o};
        checks++;
        if (obs_v !== exp_v) begin
            errors++;
            $display("FAIL pins cycle=%0d got pop=%b bck=%b lrck=%b dat=%b ur=%b cnt=%h want pop=%b bck=%b lrck=%b dat=%b ur=%b cnt=%h",
                     n, pop_o, bck_o, lrck_o, data_o, underrun_o, underrun_cnt_o,
                     e_pop, e_bck, e_lr, e_dat, e_ur, 16'(ucnt_m));
        end
        if (underrun_o === 1'b1) pulses++;
        if (data_o === 1'b1) ones++;
    endtask

    task automatic drive();
        ack_i = {plan[1][n][24], plan[0][n][24]};
        if (plan[0][n][24])      data_i = plan[0][n][23:0];
        else if (plan[1][n][24]) data_i = plan[1][n][23:0];
        else                     data_i = 24'($urandom);
    endtask

    task automatic run_until(input int last);
        while (n <= last && n < MAXC) begin
            check_cycle();
            drive();
            @(posedge clk);
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if ({pop_o, bck_o, lrck_o, data_o, underrun_o, underrun_cnt_o} !== 22'd0) begin
            errors++;
            $display("FAIL %s got pop=%b bck=%b lrck=%b dat=%b ur=%b cnt=%h want all zero",
                     name, pop_o, bck_o, lrck_o, data_o, underrun_o, underrun_cnt_o);
        end
    endtask

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    // Leaves the bench at a falling edge with reset just released, i.e. at cycle 0 of frame 0.
    task automatic do_reset();
        rst    = 1'b0;
        ack_i  = '0;
        data_i = '0;
        clear_state();
        repeat (2) @(negedge clk);
        check_zero("reset_hold");
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        run_until(300);
    endtask

    task automatic test_stream();
        do_reset();
        for (int f = 0; f < 5; f++) begin
            plan_ack(0, f * 256 + 18,  24'h800001);
            plan_ack(1, f * 256 + 146, 24'h7FFFFE);
        end
        run_until(5 * 256);
        check_val("stream_l_f0", rx_slot[0], 32'h0);
        for (int f = 1; f < 4; f++) begin
            check_val("stream_l", rx_slot[2 * f],     {1'b0, 24'h800001, 7'b0});
            check_val("stream_r", rx_slot[2 * f + 1], {1'b0, 24'h7FFFFE, 7'b0});
        end
        check_val("stream_ucnt", 32'(underrun_cnt_o), 32'd0);
    endtask

    task automatic test_no_ack();
        do_reset();
        run_until(3 * 256);
        check_val("noack_ones", ones, 0);
        check_val("noack_pulses", pulses, 0);
    endtask

    task automatic test_underrun();
        do_reset();
        plan_ack(0, 18, 24'($urandom));
        for (int f = 0; f < 6; f++) plan_ack(1, f * 256 + 146, 24'($urandom));
        plan_ack(0, 4 * 256 + 18, 24'($urandom));
        run_until(1500);
        check_val("urun_cnt", 32'(underrun_cnt_o), 32'd3);
        check_val("urun_pulses", pulses, 3);
        for (int f = 2; f < 5; f++) check_val("urun_zero_slot", rx_slot[2 * f], 32'h0);
    endtask

    task automatic test_ack_at_load();
        do_reset();
        plan_ack(0, 18, 24'($urandom));
        plan_ack(0, 512, 24'h123456);
        run_until(700);
        check_val("atload_word", rx_slot[4], {1'b0, 24'h123456, 7'b0});
        check_val("atload_ucnt", 32'(underrun_cnt_o), 32'd0);
    endtask

    task automatic test_saturate();
        do_reset();
        plan_ack(0, 18, 24'($urandom));
        run_until(299);
        dut.urun_cnt = 16'hFFFC;
        ucnt_m       = 16'hFFFC;
        #1;
        run_until(1600);
        check_val("sat_cnt", 32'(underrun_cnt_o), 32'h0000FFFF);
        check_val("sat_pulses", pulses, 5);
    endtask

    task automatic test_midframe_reset();
        do_reset();
        for (int f = 0; f < 3; f++) begin
            plan_ack(0, f * 256 + 20,  24'($urandom));
            plan_ack(1, f * 256 + 150, 24'($urandom));
        end
        run_until(159);
        rst   = 1'b0;
        ack_i = '0;
        #1;
        check_zero("midreset_async");
        do_reset();
        for (int f = 0; f < 3; f++) begin
            plan_ack(0, f * 256 + 18,  24'hABCDEF);
            plan_ack(1, f * 256 + 146, 24'h0F0F0F);
        end
        run_until(3 * 256);
        check_val("midreset_l", rx_slot[2], {1'b0, 24'hABCDEF, 7'b0});
        check_val("midreset_r", rx_slot[3], {1'b0, 24'h0F0F0F, 7'b0});
    endtask

    task automatic test_random();
        int p, k;
        do_reset();
        for (int f = 0; f < 14; f++) begin
            for (int ch = 0; ch < 2; ch++) begin
                p = f * 256 + (ch == 0 ? 16 : 144);
                if ($urandom_range(4, 0) != 0) begin
                    k = p + int'($urandom_range(240, 1));
                    if (k < MAXC && !plan[1-ch][k][24]) plan_ack(ch, k, 24'($urandom));
                    if ($urandom_range(3, 0) == 0) begin
                        k = p + int'($urandom_range(240, 1));
                        if (k < MAXC && !plan[1-ch][k][24]) plan_ack(ch, k, 24'($urandom));
                    end
                end
            end
        end
        run_until(14 * 256 + 100);
        check_val("random_ucnt", 32'(underrun_cnt_o), 32'(ucnt_m));
    endtask

    initial begin
        rst    = 1'b0;
        ack_i  = '0;
        data_i = '0;
        test_reset();
        test_stream();
        test_no_ack();
        test_underrun();
        test_ack_at_load();
        test_saturate();
        test_midframe_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dac_i2s_tx.md
# dac_i2s_tx

Output stage of the mix path: pulls 24-bit stereo samples from the mixer over the pop/ack handshake and serialises them as a standard I2S stream (64 BCK per frame) to the external DAC. Runs in the 49.152 MHz mix domain, 192 kHz output. Double-buffers each channel so mixer latency up to one frame is tolerated. Detects and counts underruns.

## Interface
- CLK_PER_BCK_LOG2, default 2: clk cycles per BCK = 2^N. 2 → 12.288 MHz BCK, 192 kHz fs at 49.152 MHz.
- clk  in  1  mix clock, 49.152 MHz
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- pop_o  out  2  sample request; bit0 = left, bit1 = right; one-cycle pulse
- data_i  in  24  sample from mixer, two's complement
- ack_i  in  2  data_i valid for channel bit; one cycle, any latency ≥1 after pop
- bck_o  out  1  I2S bit clock
- lrck_o  out  1  word select; 0 = left
- data_o  out  1  serial data, MSB first
- underrun_o  out  1  one-cycle pulse on underrun
- underrun_cnt_o  out  16  saturating underrun count

## Operation
- Frame counter cnt, width 6+CLK_PER_BCK_LOG2 (8 bits at default), free-running, wraps. Bit index b = cnt[MSB:LOG2], 0..63; phase p = cnt[LOG2-1:0].
- bck_o = cnt[LOG2-1] registered: low for first half of bit, high for second. DAC samples on rising edge.
- lrck_o = b[5] registered: left slot b=0..31, right slot b=32..63.
- Slot layout (I2S): slot bit 0 = 0, bits 1..24 = sample[23:0] MSB first, bits 25..31 = 0.
- Per channel: pending register (24b), pend_v flag, primed flag.
- Pop schedule: pop_o[0] at cnt = 0x10; pop_o[1] at cnt = 0x90 (default scaling: b=4 / b=36).
- ack_i[c]: pending_c <= data_i, pend_v_c <= 1, primed_c <= 1. Ack with pend_v already set overwrites, no error. ack_i = 2'b11: both channels capture data_i (protocol violation, not flagged).
- Load: left at cnt = 0x00, right at cnt = 0x80. Shift register (32b) <= {1'b0, sample, 7'b0}; pend_v_c <= 0.
- Load source: if ack_i[c] same cycle → data_i (bypass, on time); else if pend_v_c → pending_c; else zero.
- Underrun: load with no valid data while primed_c = 1 → underrun_o pulse, underrun_cnt_o += 1, saturating at 0xFFFF. Unprimed loads (after reset, before first ack) are silent zeros.
- Shift on each bit boundary (p = 0, excluding load cycles); data_o <= shift[31] at same edge as bck_o falls.
- Outstanding pop not acked before next pop of same channel: no retry; pop proceeds on schedule.

## Timing
- Reset (rst low): cnt 0, bck_o 0, lrck_o 0, data_o 0, pop_o 0, underrun_o 0, underrun_cnt_o 0, pending/pend_v/primed/shift 0. Mid-frame reset aborts the frame immediately; restart from b=0.
- Acks latch in cycle received; pending visible next cycle.
- Load-to-pin: shift loaded at cnt = 0x00, slot bit 0 on data_o from cycle 1; MSB on data_o one BCK later (cnt = 0x05 at default).
- bck_o, lrck_o, data_o all registered, aligned to the same edge; lrck_o changes with bck_o falling.
- Ack deadline for left: up to and including cycle cnt = 0x00 of next frame (240 cycles after pop at default).
- Frame period 256 clk; pop_o duty one cycle per channel per frame.

## Structure
- Shared package dmix_pkg: I2S_FRAME_BITS = 64, I2S_SLOT_BITS = 32, SAMPLE_W = 24, POP_BIT_L = 4, POP_BIT_R = 36; channel index constants CH_L = 0, CH_R = 1.
- Sub-module dac_i2s_chbuf: one per channel; pending register, pend_v/primed flags, bypass mux, underrun pulse output. Top holds counter, shifter, output regs, saturating counter.

## Test plan
- Reset release, mixer acks 2 cycles after each pop with L = 0x800001, R = 0x7FFFFE → from frame 2, left slot bits 1..24 = 100…001, right = 011…110, other bits 0; underrun_cnt_o stays 0.
- No acks ever after reset → data_o constant 0, underrun_o never pulses.
- Ack left once, then withhold left acks for 3 frames → 3 underrun_o pulses at cnt = 0x00, counter = 3, zeros in left slots.
- Left ack exactly at cnt = 0x00 with 0x123456 → sample transmitted that frame, no underrun.
- Preload underrun_cnt_o to 0xFFFF via forced underruns → stays 0xFFFF, pulse still asserted.
- Assert rst at b = 40 → outputs 0 asynchronously; after release first pop_o[0] at cnt = 0x10, waveform matches fresh reset.
